// File: rtl/baud_pkg.sv
// baud_pkg: constants and types shared by the baud tick generator.
//   DEFAULT_OSR     default oversample ratio
//   DEFAULT_FRAC_W  default number of fractional divisor bits
//   MIN_DIV_INT     smallest integer divisor that still yields distinct ticks
//   div_state_t     state encoding of the restoring divider
package baud_pkg;

    localparam int DEFAULT_OSR    = 16;
    localparam int DEFAULT_FRAC_W = 4;
    localparam int MIN_DIV_INT    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/baud_divider.sv
// baud_divider: restoring shift-subtract divider, one quotient bit per clock.
//   clock     in   system clock
//   Reset     in   synchronous, active-high
//   start     in   accepted in IDLE/DONE; latches dividend and divisor
//   dividend  in   N_W-bit numerator
//   divisor   in   D_W-bit denominator
//   busy      out  high from the cycle after start for 1 + N_W cycles
//   done      out  high in the final iteration cycle; quotient valid then
//   quotient  out  final quotient (valid while done is high)
//   div_zero  out  latched divisor was zero (quotient meaningless)
//
// state | meaning
// IDLE  | waiting for start
// SETUP | clear remainder, arm iteration counter
// ITER  | one quotient bit per cycle, MSB first
// DONE  | result registered; behaves like IDLE for a new start
module baud_divider
    import baud_pkg::*;
#(
    parameter int N_W = 34,
    parameter int D_W = 24
) (
    input  logic           clock,
    input  logic           Reset,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic           div_zero
);

    localparam int CNT_W = $clog2(N_W);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(N_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    div_state_t     state;
    logic [D_W-1:0] den_r;
    logic [D_W-1:0] rem_r;
    logic [N_W-1:0] quo_r;
    logic [CNT_W-1:0] cnt_r;
    logic [D_W:0]   shifted;
    logic [D_W:0]   diff;
    logic           fits;

    // quo_r doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        shifted = {rem_r, quo_r[N_W-1]};
        diff    = shifted - {1'b0, den_r};
        fits    = (shifted >= {1'b0, den_r});
    end

    assign quotient = {quo_r[N_W-2:0], fits};
    assign done     = (state == ITER) && (cnt_r == '0);
    assign busy     = (state == SETUP) || (state == ITER);

    always_ff @(posedge clock) begin
        if (Reset) begin
            state    <= IDLE;
            den_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt_r    <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        quo_r <= dividend;
                        den_r <= divisor;
                        state <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP: begin
                    rem_r    <= '0;
                    cnt_r    <= LAST_IT;
                    div_zero <= (den_r == '0);
                    state    <= ITER;
                end
                ITER: begin
                    // when the subtraction fails, shifted < den_r so it fits D_W bits
                    rem_r <= fits ? diff[D_W-1:0] : shifted[D_W-1:0];
                    quo_r <= quotient;
                    if (cnt_r == '0) begin
                        state <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional baud-tick generator with hardware divisor.
//   clock           in   system clock
//   Reset           in   synchronous, active-high
//   ClockFrequency  in   system clock in Hz, sampled on accepted cfg_load
//   BaudRate        in   bit rate in bit/s, sampled on accepted cfg_load
//   cfg_load        in   pulse: latch config and start the divisor computation
//   enable          in   counters advance only while high
//   restart         in   pulse: realign tick phase to zero
//   os_tick         out  pulse at OSR x baud
//   mid_tick        out  pulse at the centre of each bit
//   bit_tick        out  pulse at the end of each bit
//   cfg_busy        out  divisor computation in progress
//   cfg_valid       out  legal divisor loaded, ticks permitted
//   cfg_error       out  last configuration was illegal
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int CLK_W  = 30,
    parameter int BAUD_W = 20,
    parameter int OSR    = DEFAULT_OSR,
    parameter int FRAC_W = DEFAULT_FRAC_W,
    parameter int QW     = CLK_W + FRAC_W
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [CLK_W-1:0]  ClockFrequency,
    input  logic [BAUD_W-1:0] BaudRate,
    input  logic              cfg_load,
    input  logic              enable,
    input  logic              restart,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_busy,
    output logic              cfg_valid,
    output logic              cfg_error
);

    localparam int OS_W  = $clog2(OSR);
    localparam int DEN_W = BAUD_W + OS_W;
    localparam logic [OS_W-1:0]  PH_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0]  PH_MID  = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]  PH_ONE  = OS_W'(1);
    localparam logic [CLK_W-1:0] ONE     = CLK_W'(1);
    localparam logic [CLK_W-1:0] MIN_INT = CLK_W'(MIN_DIV_INT);

    logic              accept;
    logic              div_done;
    logic              div_zero;
    logic [QW-1:0]     quotient;
    logic [CLK_W-1:0]  q_int;
    logic [FRAC_W-1:0] q_frac;
    logic              q_legal;
    logic [CLK_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [CLK_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [OS_W-1:0]   phase;
    logic [FRAC_W:0]   acc_sum;
    logic [CLK_W-1:0]  reload;

    assign accept  = cfg_load && !cfg_busy;
    assign q_int   = quotient[QW-1:FRAC_W];
    assign q_frac  = quotient[FRAC_W-1:0];
    assign q_legal = !div_zero && (q_int >= MIN_INT);

    // A carry out of the fractional accumulator stretches the period that
    // starts now by one clock; the reload value is period-1.
    assign acc_sum = {1'b0, acc} + {1'b0, div_frac};
    assign reload  = acc_sum[FRAC_W] ? div_int : div_int - ONE;

    // Q = ClockFrequency*2^FRAC_W / (BaudRate*OSR); both scalings are shifts.
    baud_divider #(
        .N_W (QW),
        .D_W (DEN_W)
    ) u_div (
        .clock    (clock),
        .Reset    (Reset),
        .start    (accept),
        .dividend ({ClockFrequency, {FRAC_W{1'b0}}}),
        .divisor  ({BaudRate, {OS_W{1'b0}}}),
        .busy     (cfg_busy),
        .done     (div_done),
        .quotient (quotient),
        .div_zero (div_zero)
    );

    always_ff @(posedge clock) begin
        if (Reset) begin
            os_tick   <= 1'b0;
            mid_tick  <= 1'b0;
            bit_tick  <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_error <= 1'b0;
            div_int   <= '0;
            div_frac  <= '0;
            cnt       <= '0;
            acc       <= '0;
            phase     <= '0;
        end else begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            if (accept) begin
                cfg_valid <= 1'b0;
                cnt       <= '0;
                acc       <= '0;
                phase     <= '0;
            end else if (div_done) begin
                cfg_valid <= q_legal;
                cfg_error <= !q_legal;
                div_int   <= q_int;
                div_frac  <= q_frac;
                cnt       <= q_int - ONE;
                acc       <= '0;
                phase     <= '0;
            end else if (restart && cfg_valid) begin
                cnt   <= div_int - ONE;
                acc   <= '0;
                phase <= '0;
            end else if (cfg_valid && enable) begin
                if (cnt == '0) begin
                    os_tick  <= 1'b1;
                    mid_tick <= (phase == PH_MID);
                    bit_tick <= (phase == PH_LAST);
                    phase    <= phase + PH_ONE;
                    acc      <= acc_sum[FRAC_W-1:0];
                    cnt      <= reload;
                end else begin
                    cnt <= cnt - ONE;
                end
            end
        end
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised fractional baud-tick generator for the UART TX/RX datapaths.
- Computes its own divisor in hardware from ClockFrequency and BaudRate with a multi-cycle divider. Runs a fractional-N counter from that divisor.
- Emits an oversample tick, a mid-bit sample tick and a bit tick.
- A restart input realigns the tick phase to an RX start-bit edge.

Parameters:
- CLK_W, 30, width of ClockFrequency (up to 1 GHz)
- BAUD_W, 20, width of BaudRate (up to 1,000,000)
- OSR, 16, oversample ratio; power of two, 4..64
- FRAC_W, 4, fractional divisor bits
- QW, CLK_W+FRAC_W, quotient width (derived; do not override)

Ports:
- clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- ClockFrequency  in  CLK_W  system clock frequency in Hz; sampled on cfg_load
- BaudRate  in  BAUD_W  baud rate in bit/s; sampled on cfg_load
- cfg_load  in  1  one-cycle pulse: latch inputs, start divisor computation
- enable  in  1  tick counters advance only when high
- restart  in  1  one-cycle pulse: realign phase to zero
- os_tick  out  1  one-cycle pulse at OSR x baud rate
- mid_tick  out  1  one-cycle pulse at the centre of each bit
- bit_tick  out  1  one-cycle pulse at the end of each bit
- cfg_busy  out  1  divisor computation in progress
- cfg_valid  out  1  valid divisor loaded; ticks permitted
- cfg_error  out  1  last configuration illegal

Behaviour:
- Reset state:
  - Reset=1 at a clock edge: all outputs 0, all counters 0, accumulator 0, divider idle.
  - No ticks are produced until the first successful configuration.
- Configuration:
  - cfg_load sampled high while cfg_busy=0: latch both inputs; cfg_busy=1 and cfg_valid=0 from the next cycle.
  - cfg_load while cfg_busy=1 is ignored.
- Divider:
  - Restoring shift-subtract divide, one quotient bit per clock.
  - Q = floor(ClockFrequency * 2^FRAC_W / (BaudRate * OSR)).
  - cfg_busy is high for exactly QW+1 cycles: one setup cycle plus QW iterations.
  - Then div_int = Q >> FRAC_W and div_frac = Q[FRAC_W-1:0] are registered.
- Legality:
  - BaudRate==0 or div_int<2: cfg_error=1, cfg_valid=0, ticks stay suppressed.
  - Otherwise: cfg_error=0, cfg_valid=1.
  - Both flags update in the cycle cfg_busy falls.
  - BaudRate==0 short-circuits: the divider still runs its full latency and its result is discarded.
- Tick counter (active when cfg_valid=1 and enable=1):
  - Down-counter is loaded with period-1 and fires os_tick for one cycle when it reaches 0. A period is therefore exactly div_int clocks, with no +1 off-by-one.
  - On each os_tick, acc <= acc + div_frac modulo 2^FRAC_W.
  - A carry out makes the next period div_int+1.
  - Average os period = Q/2^FRAC_W clocks.
- Phase counter:
  - Counts 0..OSR-1 and increments on os_tick, wrapping to 0.
  - bit_tick = os_tick and phase==OSR-1.
  - mid_tick = os_tick and phase==OSR/2-1.
  - bit_tick and os_tick assert in the same cycle; mid_tick and os_tick assert in the same cycle.
- enable=0: all counters and the accumulator hold; all tick outputs are 0.
- restart:
  - Reloads the down-counter with div_int-1, clears acc and phase, and emits no tick that cycle.
  - First os_tick comes div_int cycles later.
  - First mid_tick comes OSR/2 os periods later.
- Priority: Reset > cfg_load (accepted) > restart > normal counting.
- An accepted cfg_load suppresses ticks immediately and clears counters, acc and phase.
- After a successful configuration, counting starts from phase 0 with a fresh period.
- Ticks are registered outputs, pulse width exactly one clock. No combinational path from any input to any output.

Decomposition:
- Package baud_pkg:
  - Default OSR and FRAC_W.
  - The minimum legal div_int constant (2).
  - Divider state enum: IDLE, SETUP, ITER, DONE.
- One sub-module, baud_divider:
  - Parametrised QW-bit restoring divider with start/busy/done handshake.
  - Outputs the quotient and a divide-by-zero flag.
- baud_tick_gen holds config registers, legality check, fractional counter and phase counter.

Test Plan:
- Defaults; ClockFrequency=50_000_000, BaudRate=115200, pulse cfg_load:
  - cfg_busy high 35 cycles, then Q=434, div_int=27, div_frac=2, cfg_valid=1.
  - os_tick intervals follow seven 27s then one 28, repeating.
  - Every 16 os_ticks span exactly 434 clocks.
  - bit_tick occurs every 434 clocks.
- ClockFrequency=1_000_000, BaudRate=31250:
  - Q=32, div_int=2, frac=0.
  - os_tick every 2 clocks, mid_tick every 32 clocks starting 16 clocks after config, bit_tick every 32 clocks.
- Illegal configurations:
  - BaudRate=0 -> cfg_error=1, cfg_valid=0, no ticks over 1000 cycles.
  - BaudRate=62500 at 1 MHz (div_int=1) -> cfg_error=1, no ticks.
- restart pulse mid-bit:
  - No tick that cycle.
  - Next os_tick exactly div_int clocks later; mid_tick after OSR/2 os_ticks.
  - Phase is 0 with no spurious bit_tick.
- Disturbances:
  - enable low for 50 cycles mid-period -> ticks stop and counters hold; resume with the remaining count intact.
  - cfg_load during cfg_busy -> ignored; result equals the first configuration.
- Reset asserted during cfg_busy and during active ticking -> next cycle all outputs 0 and no ticks until a new cfg_load completes.
